// File: rtl/axis_pattern_checker.sv
// AXI-Stream end-of-chain sink: programmable backpressure, incrementing-word check.
// Define AXIS_PATTERN_CHECKER_RESYNC_EN to re-lock the expected base onto the stream after a mismatch.
module axis_pattern_checker #(
  parameter int          WORDS     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [32*WORDS-1:0]   in_tdata,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  cfg_enable,
  input  logic [1:0]            cfg_ready_mode,
  output logic [31:0]           beat_count,
  output logic [31:0]           error_count,
  output logic                  err_flag,
  output logic [31:0]           first_err_got,
  output logic [31:0]           first_err_exp
);

  localparam int DW = 32 * WORDS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FAIL = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nx;
  logic [1:0]    phase;
  logic [1:0]    phase_nx;
  logic          ready_nx;
  logic [31:0]   base;
  logic [31:0]   base_nx;
  logic          s1_valid;
  logic [DW-1:0] s1_data;
  logic [31:0]   s1_base;
  logic          mismatch;
  logic          accept;
  logic          start;
  logic          active;

  assign accept = in_tvalid & in_tready;
  assign start  = (state == IDLE) & cfg_enable;
  assign active = (state != IDLE);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (s1_data[32*i +: 32] != s1_base + 32'(i))
        mismatch = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (!cfg_enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     if (s1_valid && mismatch) state_nx = FAIL;
        FAIL:    state_nx = FAIL;
        default: state_nx = IDLE;
      endcase
    end
  end

  // x^16+x^14+x^13+x^11+1, shifting toward the MSB
  assign lfsr_nx  = active ?
    {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]} : lfsr;
  assign phase_nx = active ? phase + 2'd1 : phase;

  always_comb begin
    ready_nx = 1'b0;
    if (state_nx != IDLE) begin
      unique case (cfg_ready_mode)
        2'd0: ready_nx = 1'b1;
        2'd1: ready_nx = lfsr_nx[0];
        2'd2: ready_nx = (phase_nx == 2'd3);
        2'd3: ready_nx = 1'b0;
      endcase
    end
  end

`ifdef AXIS_PATTERN_CHECKER_RESYNC_EN
  // A correct beat has word0 == base, so following word0 is harmless then
  assign base_nx = in_tdata[31:0] + 32'(WORDS);
`else
  assign base_nx = base + 32'(WORDS);
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      phase         <= 2'd0;
      in_tready     <= 1'b0;
      base          <= 32'd0;
      s1_valid      <= 1'b0;
      s1_data       <= '0;
      s1_base       <= 32'd0;
      beat_count    <= 32'd0;
      error_count   <= 32'd0;
      err_flag      <= 1'b0;
      first_err_got <= 32'd0;
      first_err_exp <= 32'd0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      phase     <= phase_nx;
      in_tready <= ready_nx;
      s1_valid  <= accept;
      if (accept) begin
        s1_data <= in_tdata;
        s1_base <= base;
      end
      if (start)
        base <= 32'd0;
      else if (accept)
        base <= base_nx;
      if (start) begin
        beat_count    <= 32'd0;
        error_count   <= 32'd0;
        err_flag      <= 1'b0;
        first_err_got <= 32'd0;
        first_err_exp <= 32'd0;
      end else if (s1_valid) begin
        if (beat_count != 32'hFFFF_FFFF)
          beat_count <= beat_count + 32'd1;
        if (mismatch) begin
          if (error_count != 32'hFFFF_FFFF)
            error_count <= error_count + 32'd1;
          if (!err_flag) begin
            err_flag      <= 1'b1;
            first_err_got <= s1_data[31:0];
            first_err_exp <= s1_base;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pattern_checker.sv
// Scoreboard bench for axis_pattern_checker; models the incrementing-word pattern
// and the counters, and compares them when each accepted beat finishes its compare.
module tb_axis_pattern_checker;

  localparam int WORDS = 8;
  localparam int DW    = 32 * WORDS;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] in_tdata = '0;
  logic          in_tvalid = 1'b0;
  logic          in_tready;
  logic          cfg_enable = 1'b0;
  logic [1:0]    cfg_ready_mode = 2'd0;
  logic [31:0]   beat_count;
  logic [31:0]   error_count;
  logic          err_flag;
  logic [31:0]   first_err_got;
  logic [31:0]   first_err_exp;

  int checks = 0;
  int errors = 0;

  axis_pattern_checker #(.WORDS(WORDS), .LFSR_SEED(16'hACE1)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .in_tdata      (in_tdata),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .cfg_enable    (cfg_enable),
    .cfg_ready_mode(cfg_ready_mode),
    .beat_count    (beat_count),
    .error_count   (error_count),
    .err_flag      (err_flag),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned due;
    logic        bad;
    logic [31:0] got;
    logic [31:0] exp;
  } item_t;

  item_t       sb[$];
  int unsigned cyc = 0;
  logic [31:0] mbase = 0, mbeats = 0, merr = 0, mgot = 0, mexp = 0;
  logic        mflag = 1'b0;
  logic        mrun = 1'b0;

  // Accepts seen before edge n+1 show up in the counters after edge n+2
  always @(negedge aclk) begin
    item_t it;
    logic  bad;
    cyc++;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      it = sb.pop_front();
      if (mbeats != 32'hFFFF_FFFF) mbeats++;
      if (it.bad) begin
        if (merr != 32'hFFFF_FFFF) merr++;
        if (!mflag) begin
          mflag = 1'b1;
          mgot  = it.got;
          mexp  = it.exp;
        end
      end
      chk("beat_count", beat_count, mbeats);
      chk("error_count", error_count, merr);
      chk("err_flag", 32'(err_flag), 32'(mflag));
      chk("first_err_got", first_err_got, mgot);
      chk("first_err_exp", first_err_exp, mexp);
    end
    if (areset) begin
      sb.delete();
      mrun = 1'b0;
      mbase = 0; mbeats = 0; merr = 0; mgot = 0; mexp = 0; mflag = 1'b0;
    end else begin
      if (!cfg_enable) begin
        mrun = 1'b0;
      end else if (!mrun) begin
        mrun = 1'b1;
        mbase = 0; mbeats = 0; merr = 0; mgot = 0; mexp = 0; mflag = 1'b0;
      end
      if (in_tvalid && in_tready) begin
        bad = 1'b0;
        for (int i = 0; i < WORDS; i++)
          if (in_tdata[32*i +: 32] != mbase + 32'(i)) bad = 1'b1;
        it.due = cyc + 2;
        it.bad = bad;
        it.got = in_tdata[31:0];
        it.exp = mbase;
        sb.push_back(it);
`ifdef AXIS_PATTERN_CHECKER_RESYNC_EN
        mbase = in_tdata[31:0] + 32'(WORDS);
`else
        mbase = mbase + 32'(WORDS);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic start(input logic [1:0] mode);
    cfg_ready_mode = mode;
    cfg_enable = 1'b1;
    tick();
  endtask

  task automatic stop();
    in_tvalid = 1'b0;
    cfg_enable = 1'b0;
    repeat (4) tick();
  endtask

  task automatic send(input logic [31:0] w0, input int cw,
                      input logic [31:0] cv, input bit rnd,
                      output int waited);
    bit done;
    bit r;
    for (int i = 0; i < WORDS; i++)
      in_tdata[32*i +: 32] = w0 + 32'(i);
    if (cw >= 0) in_tdata[32*cw +: 32] = cv;
    waited = 0;
    done = 1'b0;
    while (!done && waited < 300) begin
      in_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      r = in_tvalid && in_tready;
      tick();
      waited++;
      if (r) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"}, 32'(in_tready), 32'd0);
    chk({tag, "_beats"}, beat_count, 32'd0);
    chk({tag, "_errs"}, error_count, 32'd0);
    chk({tag, "_flag"}, 32'(err_flag), 32'd0);
    chk({tag, "_got"}, first_err_got, 32'd0);
    chk({tag, "_exp"}, first_err_exp, 32'd0);
  endtask

  initial begin
    int w;
    int tot;
    repeat (3) tick();
    areset = 1'b0;
    tick();
    chk_zero("reset");

    // mode 0, full rate
    start(2'd0);
    tot = 0;
    for (int k = 0; k < 100; k++) begin
      send(32'(8 * k), -1, 32'd0, 1'b0, w);
      tot += w;
    end
    chk("m0_cycles", 32'(tot), 32'd100);
    stop();
    chk("m0_beats", beat_count, 32'd100);
    chk("m0_errs", error_count, 32'd0);
    chk("m0_flag", 32'(err_flag), 32'd0);
    chk("idle_tready", 32'(in_tready), 32'd0);

    // mode 2, one ready cycle in four
    start(2'd2);
    for (int k = 0; k < 20; k++) begin
      send(32'(8 * k), -1, 32'd0, 1'b0, w);
      if (k > 0) chk("m2_gap", 32'(w), 32'd4);
    end
    stop();
    chk("m2_beats", beat_count, 32'd20);
    chk("m2_errs", error_count, 32'd0);

    // beat 5 word 3 corrupted
    start(2'd0);
    for (int k = 0; k < 20; k++)
      send(32'(8 * k), (k == 5) ? 3 : -1, 32'hDEAD_BEEF, 1'b0, w);
    in_tvalid = 1'b0;
    repeat (3) tick();
    chk("fail_tready", 32'(in_tready), 32'd1);
    stop();
    chk("cor_errs", error_count, 32'd1);
    chk("cor_flag", 32'(err_flag), 32'd1);
    chk("cor_got", first_err_got, 32'd40);
    chk("cor_exp", first_err_exp, 32'd40);

    // beat 10 dropped
    start(2'd0);
    for (int k = 0; k < 20; k++)
      if (k != 10) send(32'(8 * k), -1, 32'd0, 1'b0, w);
    stop();
`ifdef AXIS_PATTERN_CHECKER_RESYNC_EN
    chk("drop_errs", error_count, 32'd1);
`else
    chk("drop_errs", error_count, 32'd9);
`endif
    chk("drop_got", first_err_got, 32'd88);
    chk("drop_exp", first_err_exp, 32'd80);

`ifdef AXIS_PATTERN_CHECKER_RESYNC_EN
    // resync onto the top of the word space, then wrap to 0
    start(2'd0);
    send(32'hFFFF_FFF8, -1, 32'd0, 1'b0, w);
    send(32'd0, -1, 32'd0, 1'b0, w);
    send(32'd8, -1, 32'd0, 1'b0, w);
    send(32'd16, -1, 32'd0, 1'b0, w);
    stop();
    chk("wrap_beats", beat_count, 32'd4);
    chk("wrap_errs", error_count, 32'd1);
    chk("wrap_got", first_err_got, 32'hFFFF_FFF8);
    chk("wrap_exp", first_err_exp, 32'd0);
`endif

    // reset pulse right after an accept, then restart
    start(2'd1);
    for (int k = 0; k < 7; k++)
      send(32'(8 * k), -1, 32'd0, 1'b1, w);
    areset = 1'b1;
    in_tvalid = 1'b0;
    cfg_enable = 1'b0;
    tick();
    areset = 1'b0;
    chk_zero("midrst");
    start(2'd1);
    for (int k = 0; k < 10; k++)
      send(32'(8 * k), -1, 32'd0, 1'b1, w);
    stop();
    chk("rst_beats", beat_count, 32'd10);
    chk("rst_errs", error_count, 32'd0);
    chk("rst_flag", 32'(err_flag), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
